hex_entry: RTL and testbench

HEX_ENTRY -- requirements
Module: hex_entry

---
 rtl/hex_entry.sv | 148 ++++++++++++++
 tb/tb_hex_entry.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry.sv
// Hex value editor: buttons pick a nibble and step it, and C hands the value to the core.
// Define HEX_ENTRY_AUTO_REPEAT_EN to make U/D auto-repeat while they are held.
module hex_entry #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dBTNL,
  input  logic        dBTNR,
  input  logic        dBTNU,
  input  logic        dBTND,
  input  logic        dBTNC,
  output logic [31:0] entry_val,
  output logic [2:0]  cursor,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        busy
);

  // state  | meaning
  // EDIT   | buttons edit entry_val / cursor
  // COMMIT | wr_valid held until the core accepts wr_data; buttons ignored
  typedef enum logic {S_EDIT = 1'b0, S_COMMIT = 1'b1} state_t;

  state_t state, state_nxt;

  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_bad_delay
    $error("hex_entry: REPEAT_DELAY must be 1..255");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_rate
    $error("hex_entry: REPEAT_RATE must be 1..255");
  end

  logic [4:0] btn, btn_prev, ev;
  logic       ev_c, ev_u, ev_d, ev_l, ev_r;
  logic       rpt_u, rpt_d;
  logic       in_edit;
  logic       act_c, act_u, act_d, act_l, act_r;
  logic [3:0] nib;

  assign btn = {dBTNC, dBTNU, dBTND, dBTNL, dBTNR};
  assign ev  = btn & ~btn_prev;
  assign {ev_c, ev_u, ev_d, ev_l, ev_r} = ev;
  assign in_edit = (state == S_EDIT);

  // Previous levels reset high so a button held through reset must be re-pressed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) btn_prev <= 5'b11111;
    else      btn_prev <= btn;
  end

`ifdef HEX_ENTRY_AUTO_REPEAT_EN
  localparam logic [7:0] RPT_DELAY_C = 8'(REPEAT_DELAY);
  localparam logic [7:0] RPT_RATE_C  = 8'(REPEAT_RATE);

  logic [7:0] rpt_cnt;
  logic [1:0] held, held_q;
  logic       held_press, rpt_fire;

  // U wins over D when both are held.
  always_comb begin
    held = 2'd0;
    if (dBTNU)      held = 2'd1;
    else if (dBTND) held = 2'd2;
  end

  assign held_press = (held == 2'd1 && ev_u) || (held == 2'd2 && ev_d);
  assign rpt_fire   = in_edit && !held_press && (held != 2'd0) &&
                      (held == held_q) && (rpt_cnt == 8'd1);
  assign rpt_u      = rpt_fire && (held_q == 2'd1);
  assign rpt_d      = rpt_fire && (held_q == 2'd2);

  // Down-counter armed only by a real press edge; 0 means idle, 1 is terminal count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rpt_cnt <= 8'd0;
      held_q  <= 2'd0;
    end else begin
      held_q <= held;
      if (in_edit && held_press)
        rpt_cnt <= RPT_DELAY_C;
      else if (!in_edit || held == 2'd0 || held != held_q)
        rpt_cnt <= 8'd0;
      else if (rpt_cnt == 8'd1)
        rpt_cnt <= RPT_RATE_C;
      else if (rpt_cnt != 8'd0)
        rpt_cnt <= rpt_cnt - 8'd1;
    end
  end
`else
  assign rpt_u = 1'b0;
  assign rpt_d = 1'b0;
`endif

  // One action per cycle, C > U > D > L > R; losers are dropped.
  always_comb begin
    act_c = 1'b0;
    act_u = 1'b0;
    act_d = 1'b0;
    act_l = 1'b0;
    act_r = 1'b0;
    if (in_edit) begin
      if (ev_c)               act_c = 1'b1;
      else if (ev_u || rpt_u) act_u = 1'b1;
      else if (ev_d || rpt_d) act_d = 1'b1;
      else if (ev_l)          act_l = 1'b1;
      else if (ev_r)          act_r = 1'b1;
    end
  end

  assign nib = entry_val[{cursor, 2'b00} +: 4];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_EDIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EDIT:   if (act_c)    state_nxt = S_COMMIT;
      S_COMMIT: if (wr_ready) state_nxt = S_EDIT;
      default:  state_nxt = S_EDIT;
    endcase
  end

  always_comb begin
    busy     = (state == S_COMMIT);
    wr_valid = (state == S_COMMIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      entry_val <= 32'd0;
      cursor    <= 3'd0;
      wr_data   <= 32'd0;
    end else begin
      if (act_c) wr_data <= entry_val;
      if (act_u) entry_val[{cursor, 2'b00} +: 4] <= nib + 4'd1;
      if (act_d) entry_val[{cursor, 2'b00} +: 4] <= nib - 4'd1;
      if (act_l) cursor <= cursor + 3'd1;
      if (act_r) cursor <= cursor - 3'd1;
    end
  end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: scoreboarded button presses, commit handshake, reset cases.
module tb_hex_entry;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        dBTNL = 1'b0, dBTNR = 1'b0, dBTNU = 1'b0, dBTND = 1'b0, dBTNC = 1'b0;
  logic        wr_ready = 1'b0;
  logic [31:0] entry_val, wr_data;
  logic [2:0]  cursor;
  logic        wr_valid, busy;

  hex_entry #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
    .CLK(CLK), .RST(RST),
    .dBTNL(dBTNL), .dBTNR(dBTNR), .dBTNU(dBTNU), .dBTND(dBTND), .dBTNC(dBTNC),
    .entry_val(entry_val), .cursor(cursor),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] val;
    logic [2:0]  cur;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] commit_q[$];
  logic [31:0] m_val;
  logic [2:0]  m_cur;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    {dBTNC, dBTNU, dBTND, dBTNL, dBTNR} = m;
  endtask

  // m = {C,U,D,L,R}; C is exercised separately in the commit sequence.
  task automatic press(input logic [4:0] m, input string tag);
    exp_t e;
    logic [3:0] n;
    e.val = m_val;
    e.cur = m_cur;
    n = m_val[m_cur*4 +: 4];
    if (m[3])      e.val[m_cur*4 +: 4] = n + 4'd1;
    else if (m[2]) e.val[m_cur*4 +: 4] = n - 4'd1;
    else if (m[1]) e.cur = m_cur + 3'd1;
    else if (m[0]) e.cur = m_cur - 3'd1;
    exp_q.push_back(e);
    m_val = e.val;
    m_cur = e.cur;
    set_btns(m);
    tick();
    set_btns(5'b0);
    e = exp_q.pop_front();
    check({tag, " val"}, entry_val, e.val);
    check({tag, " cur"}, {29'd0, cursor}, {29'd0, e.cur});
    tick();
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    wr_ready = 1'b0;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    m_val = 32'd0;
    m_cur = 3'd0;
  endtask

  task automatic set_value(input logic [31:0] target);
    for (int i = 0; i < 8; i++) begin
      while (m_cur != 3'(i)) press(5'b00010, "nav L");
      while (m_val[i*4 +: 4] != target[i*4 +: 4]) press(5'b01000, "set U");
    end
  endtask

  logic [31:0] exp_w;
  logic [31:0] rpt_exp;

  initial begin
    m_val = 32'd0;
    m_cur = 3'd0;
    #2;
    check("rst entry_val", entry_val, 32'd0);
    check("rst cursor", {29'd0, cursor}, 32'd0);
    check("rst wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst wr_data", wr_data, 32'd0);
    tick();
    RST = 1'b1;
    tick();

    repeat (3) press(5'b01000, "inc U");
    check("three U", entry_val, 32'h0000_0003);

    press(5'b00001, "R wrap");
    check("R wrap cursor", {29'd0, cursor}, 32'd7);
    press(5'b00100, "D wrap");
    check("D wrap val", entry_val, 32'hF000_0003);
    press(5'b01000, "U wrap");
    check("U no carry", entry_val, 32'h0000_0003);
    press(5'b00010, "L wrap");

    // wr_ready while idle must not raise anything
    do_reset();
    wr_ready = 1'b1;
    repeat (3) tick();
    check("idle ready wr_valid", {31'd0, wr_valid}, 32'd0);
    wr_ready = 1'b0;

    set_value(32'h1234_5678);
    check("set value", entry_val, 32'h1234_5678);

    dBTNC = 1'b1;
    commit_q.push_back(m_val);
    tick();
    dBTNC = 1'b0;
    check("commit wr_valid", {31'd0, wr_valid}, 32'd1);
    check("commit busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      dBTNU = (k % 2 == 0);
      tick();
      check("hold wr_valid", {31'd0, wr_valid}, 32'd1);
      check("hold wr_data", wr_data, 32'h1234_5678);
      check("hold entry", entry_val, 32'h1234_5678);
    end
    dBTNU = 1'b0;
    tick();
    wr_ready = 1'b1;
    dBTNU = 1'b1;
    if (wr_valid && wr_ready && commit_q.size() > 0) begin
      exp_w = commit_q.pop_front();
      check("handshake data", wr_data, exp_w);
    end else begin
      check("handshake valid", {31'd0, wr_valid}, 32'd1);
    end
    tick();
    wr_ready = 1'b0;
    dBTNU = 1'b0;
    check("accept wr_valid", {31'd0, wr_valid}, 32'd0);
    check("accept busy", {31'd0, busy}, 32'd0);
    check("return press dropped", entry_val, 32'h1234_5678);
    tick();
    press(5'b01000, "edit after commit");
    check("retained edit", entry_val, 32'h2234_5678);

    // reset in the middle of a commit drops the request
    dBTNC = 1'b1;
    tick();
    dBTNC = 1'b0;
    check("commit2 wr_valid", {31'd0, wr_valid}, 32'd1);
    tick();
    RST = 1'b0;
    #1;
    check("async rst wr_valid", {31'd0, wr_valid}, 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst wr_data", wr_data, 32'd0);
    check("async rst entry", entry_val, 32'd0);
    tick();
    RST = 1'b1;
    wr_ready = 1'b1;
    repeat (2) tick();
    check("post rst wr_valid", {31'd0, wr_valid}, 32'd0);
    wr_ready = 1'b0;
    m_val = 32'd0;
    m_cur = 3'd0;

    do_reset();
    press(5'b00010, "to cur1");
    press(5'b00010, "to cur2");
    press(5'b01010, "U+L same cycle");
    check("U over L val", entry_val, 32'h0000_0100);
    check("U over L cur", {29'd0, cursor}, 32'd2);

    // U held across reset release
    dBTNU = 1'b1;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    repeat (12) tick();
    check("held thru reset", entry_val, 32'd0);
    dBTNU = 1'b0;
    tick();
    m_val = 32'd0;
    m_cur = 3'd0;
    press(5'b01000, "re-press U");
    check("re-press val", entry_val, 32'd1);

    do_reset();
`ifdef HEX_ENTRY_AUTO_REPEAT_EN
    rpt_exp = 32'd4;
`else
    rpt_exp = 32'd1;
`endif
    dBTNU = 1'b1;
    repeat (10) tick();
    dBTNU = 1'b0;
    repeat (3) tick();
    check("auto repeat", entry_val, rpt_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
